alu_arbiter: RTL

Shares one ALU instance between two requesters using a valid/ready request and response handshake. Arbitration is round-robin. The block holds operands and opcode stable for the whole operation, including multi-cycle DIV/RMOD, until the ALU signals done. It returns the result to the granted requester. Illegal opcodes and hung operations are detected and answered with an error response. It sits between the core's issue logic (requester 0) and a coprocessor/debug port (requester 1) on one side and the ALU on the other.

---
 rtl/alu_pkg.sv | 44 ++++
 rtl/rr_arbiter2.sv | 36 +++
 rtl/alu_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode map, FSM encoding and opcode classification helpers
// for the two-requester ALU arbiter.
package alu_pkg;

  localparam logic [4:0] OP_ADD  = 5'h00;
  localparam logic [4:0] OP_SUB  = 5'h01;
  localparam logic [4:0] OP_MUL  = 5'h02;
  localparam logic [4:0] OP_DIV  = 5'h03;
  localparam logic [4:0] OP_RMOD = 5'h04;
  localparam logic [4:0] OP_AND  = 5'h05;
  localparam logic [4:0] OP_OR   = 5'h06;
  localparam logic [4:0] OP_XOR  = 5'h07;
  localparam logic [4:0] OP_NOR  = 5'h08;
  localparam logic [4:0] OP_SLL  = 5'h09;
  localparam logic [4:0] OP_SRL  = 5'h0A;
  localparam logic [4:0] OP_SRA  = 5'h0B;
  localparam logic [4:0] OP_SLT  = 5'h0C;
  localparam logic [4:0] OP_SLTU = 5'h0D;
  localparam logic [4:0] OP_EQ   = 5'h0E;
  localparam logic [4:0] OP_MIN  = 5'h10;
  localparam logic [4:0] OP_MAX  = 5'h11;
  localparam logic [4:0] OP_MINU = 5'h12;
  localparam logic [4:0] OP_MAXU = 5'h13;
  localparam logic [4:0] OP_LT   = 5'h14;
  localparam logic [4:0] OP_NEQ  = 5'h15;

  // Driven whenever the ALU is not executing; the divider treats it as stop.
  localparam logic [4:0] ALU_IDLE_OP = 5'b11111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic is_legal_op(input logic [4:0] op);
    return (op <= OP_EQ) || ((op >= OP_MIN) && (op <= OP_NEQ));
  endfunction

  function automatic logic is_div_op(input logic [4:0] op);
    return (op == OP_DIV) || (op == OP_RMOD);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; a tie goes to the requester not granted last.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_valid,
  input  logic       update,
  output logic [1:0] grant,
  output logic       grant_idx
);

  logic last_grant_reg;

  always_comb begin
    grant_idx = 1'b0;
    grant     = 2'b00;
    case (req_valid)
      2'b01:   grant_idx = 1'b0;
      2'b10:   grant_idx = 1'b1;
      2'b11:   grant_idx = ~last_grant_reg;
      default: grant_idx = 1'b0;
    endcase
    if (req_valid != 2'b00) begin
      grant = grant_idx ? 2'b10 : 2'b01;
    end
  end

  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_reg <= 1'b1;
    end else if (update) begin
      last_grant_reg <= grant_idx;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two valid/ready requesters, holding operands for
// multi-cycle ops and answering illegal or hung operations with an error.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int BIT_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [9:0]             req_op,
  input  logic [2*BIT_WIDTH-1:0] req_a,
  input  logic [2*BIT_WIDTH-1:0] req_b,
  output logic [1:0]             resp_valid,
  input  logic [1:0]             resp_ready,
  output logic [BIT_WIDTH-1:0]   resp_result,
  output logic                   resp_error,
  output logic                   busy,
  output logic [BIT_WIDTH-1:0]   alu_a,
  output logic [BIT_WIDTH-1:0]   alu_b,
  output logic [4:0]             alu_control,
  input  logic                   alu_done,
  input  logic [BIT_WIDTH-1:0]   alu_result
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [4:0]           op_vec [2];
  logic [BIT_WIDTH-1:0] a_vec  [2];
  logic [BIT_WIDTH-1:0] b_vec  [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
    assign op_vec[gi] = req_op[gi*5 +: 5];
    assign a_vec[gi]  = req_a[gi*BIT_WIDTH +: BIT_WIDTH];
    assign b_vec[gi]  = req_b[gi*BIT_WIDTH +: BIT_WIDTH];
  end

  state_t               state_reg, state_next;
  logic [4:0]           op_reg, op_next;
  logic [BIT_WIDTH-1:0] a_reg, a_next;
  logic [BIT_WIDTH-1:0] b_reg, b_next;
  logic                 owner_reg, owner_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [BIT_WIDTH-1:0] result_reg, result_next;
  logic                 error_reg, error_next;

  logic [1:0] grant;
  logic       grant_idx;
  logic       accept;
  logic       done_ok;

  rr_arbiter2 u_arb (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .update    (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    state_next  = state_reg;
    op_next     = op_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    owner_next  = owner_reg;
    cnt_next    = cnt_reg;
    result_next = result_reg;
    error_next  = error_reg;
    accept      = 1'b0;
    req_ready   = 2'b00;
    resp_valid  = 2'b00;
    alu_control = ALU_IDLE_OP;
    // The divider may still report completion of an earlier op on its first cycle.
    done_ok     = alu_done && !(is_div_op(op_reg) && (cnt_reg == '0));

    case (state_reg)
      ST_IDLE: begin
        req_ready = grant;
        if (req_valid != 2'b00) begin
          accept     = 1'b1;
          owner_next = grant_idx;
          op_next    = op_vec[grant_idx];
          if (is_legal_op(op_vec[grant_idx])) begin
            a_next     = a_vec[grant_idx];
            b_next     = b_vec[grant_idx];
            cnt_next   = '0;
            state_next = ST_EXEC;
          end else begin
            result_next = '0;
            error_next  = 1'b1;
            state_next  = ST_RESP;
          end
        end
      end
      ST_EXEC: begin
        alu_control = op_reg;
        if (cnt_reg != '1) begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
        if (done_ok) begin
          result_next = alu_result;
          error_next  = 1'b0;
          state_next  = ST_RESP;
        end else if (cnt_reg == CNT_LAST) begin
          result_next = '0;
          error_next  = 1'b1;
          state_next  = ST_RESP;
        end
      end
      ST_RESP: begin
        resp_valid = owner_reg ? 2'b10 : 2'b01;
        if (resp_ready[owner_reg]) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= ST_IDLE;
      op_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      owner_reg  <= 1'b0;
      cnt_reg    <= '0;
      result_reg <= '0;
      error_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      op_reg     <= op_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      owner_reg  <= owner_next;
      cnt_reg    <= cnt_next;
      result_reg <= result_next;
      error_reg  <= error_next;
    end
  end

  assign busy        = (state_reg != ST_IDLE);
  assign alu_a       = a_reg;
  assign alu_b       = b_reg;
  assign resp_result = result_reg;
  assign resp_error  = error_reg;

endmodule
